uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter (i_Start/i_Data/busy interface) between NUM_REQ byte-stream requesters, e.g. the loopback echo path, a status reporter and a debug dump.
- Round-robin arbitration, with optional packet locking so a multi-byte message is never interleaved with another requester's bytes.
- Sequences each byte as: latch data, pulse start, wait for busy to rise, wait for busy to fall.
- Sits between the requesters and the UART module, replacing ad-hoc start/busy state machines.

---
 rtl/uart_tx_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte-stream requesters.
// Each granted byte is sequenced as: latch data (ack), pulse start, wait for busy to rise
// (bounded by BUSY_WAIT), then wait for busy to fall. A byte with i_Last=0 locks the grant
// to its requester so a multi-byte packet is never interleaved with other requesters' bytes.
//
// Ports:
//   Clock, Reset     system clock, asynchronous active-high reset
//   i_Req  [N]       per-requester byte request (level, held until ack)
//   i_Data [8N]      byte for requester k at [8k+7:8k]
//   i_Last [N]       byte from requester k ends its packet
//   o_Ack  [N]       one-cycle pulse: byte from requester k accepted
//   o_Grant[N]       one-hot current owner, zero when idle
//   o_Locked         grant held for an unfinished packet
//   o_Start          one-cycle start pulse to the UART
//   o_Data [8]       registered byte to the UART
//   i_Busy           UART busy
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BUSY_WAIT = 15
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [NUM_REQ-1:0]   i_Req,
  input  logic [8*NUM_REQ-1:0] i_Data,
  input  logic [NUM_REQ-1:0]   i_Last,
  output logic [NUM_REQ-1:0]   o_Ack,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic                 o_Locked,
  output logic                 o_Start,
  output logic [7:0]           o_Data,
  input  logic                 i_Busy
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT + 1) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWaitBusy,
    StWaitDone,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic                lock_q, lock_d;
  logic [7:0]          data_q, data_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                start_q, start_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  // Fields of the current owner selected by the one-hot grant.
  logic [PtrW-1:0] owner_idx;
  logic [7:0]      owner_data;
  logic            owner_req;
  logic            owner_last;

  always_comb begin
    owner_idx  = '0;
    owner_data = '0;
    owner_req  = 1'b0;
    owner_last = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        owner_idx  = PtrW'(k);
        owner_data = i_Data[8*k +: 8];
        owner_req  = i_Req[k];
        owner_last = i_Last[k];
      end
    end
  end

  // Round-robin pick: first requester searching upward from ptr_q+1 with wrap-around, so the
  // requester served last (ptr_q) is considered last.
  logic            rr_found;
  logic [PtrW-1:0] rr_idx;
  logic [PtrW-1:0] rr_cand;

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      rr_cand = PtrW'((32'(ptr_q) + i) % NUM_REQ);
      if (!rr_found && i_Req[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    data_d  = data_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (!i_Busy) begin
          if (lock_q) begin
            // Locked: only the packet owner may continue; everyone else waits.
            if (owner_req) state_d = StLoad;
          end else if (rr_found) begin
            grant_d = NUM_REQ'(1) << rr_idx;
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        data_d  = owner_data;
        lock_d  = !owner_last;
        state_d = StStart;
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (i_Busy) begin
          state_d = StWaitDone;
        end else if (cnt_q == CntW'(BUSY_WAIT - 1)) begin
          // UART never acknowledged the start; give up on this byte.
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitDone: begin
        if (!i_Busy) state_d = StDone;
      end
      StDone: begin
        if (lock_q) begin
          state_d = owner_req ? StLoad : StIdle;
        end else begin
          ptr_d   = owner_idx;
          grant_d = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Pulses registered so they coincide with the LOAD and START states.
    ack_d   = (state_d == StLoad) ? grant_d : '0;
    start_d = (state_d == StStart);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= PtrW'(NUM_REQ - 1);
      lock_q  <= 1'b0;
      data_q  <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_Ack    = ack_q;
  assign o_Grant  = grant_q;
  assign o_Locked = lock_q;
  assign o_Start  = start_q;
  assign o_Data   = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-requester byte queues drive i_Req/i_Data/i_Last,
// a UART model answers o_Start with busy, and a scoreboard of expected (owner, byte) pairs is
// compared against every o_Start.
module tb_uart_tx_arbiter;

  localparam int unsigned N = 4;

  logic           Clock = 1'b0;
  logic           Reset;
  logic [N-1:0]   i_Req;
  logic [8*N-1:0] i_Data;
  logic [N-1:0]   i_Last;
  logic [N-1:0]   o_Ack;
  logic [N-1:0]   o_Grant;
  logic           o_Locked;
  logic           o_Start;
  logic [7:0]     o_Data;
  logic           i_Busy;

  uart_tx_arbiter #(
    .NUM_REQ  (N),
    .BUSY_WAIT(15)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .i_Req   (i_Req),
    .i_Data  (i_Data),
    .i_Last  (i_Last),
    .o_Ack   (o_Ack),
    .o_Grant (o_Grant),
    .o_Locked(o_Locked),
    .o_Start (o_Start),
    .o_Data  (o_Data),
    .i_Busy  (i_Busy)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [1:0] own;
    logic [7:0] data;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  exp_t e_cur;
  int   start_cyc_q[$];
  logic lock_obs_q[$];

  logic [8:0] mem [N][16];
  int         hd[N];
  int         tl[N];
  bit         pend[N];
  int         ack_cnt[N];
  int         rise_cyc[N];
  logic [N-1:0] prev_req;
  int         last_ack_cyc = -10;
  int         n_starts = 0;

  int busy_delay = 2;
  int busy_len = 20;
  bit busy_never = 1'b0;

  // Requester driver plus ack/start monitor, evaluated 1 time unit after each rising edge.
  initial begin
    i_Req  = '0;
    i_Data = '0;
    i_Last = '0;
    for (int k = 0; k < N; k++) begin
      hd[k] = 0; tl[k] = 0; pend[k] = 0; ack_cnt[k] = 0; rise_cyc[k] = 0;
    end
    forever begin
      @(posedge Clock);
      cyc++;
      #1;
      // Advance past a byte only one cycle after its ack: data must hold through the ack cycle.
      for (int k = 0; k < N; k++) begin
        if (pend[k]) begin
          hd[k] = hd[k] + 1;
          pend[k] = 0;
        end
      end
      prev_req = i_Req;
      for (int k = 0; k < N; k++) begin
        if (hd[k] != tl[k]) begin
          i_Req[k] = 1'b1;
          i_Data[8*k +: 8] = mem[k][hd[k] % 16][7:0];
          i_Last[k] = mem[k][hd[k] % 16][8];
          if (!prev_req[k]) rise_cyc[k] = cyc;
        end else begin
          i_Req[k] = 1'b0;
          i_Data[8*k +: 8] = 8'h00;
          i_Last[k] = 1'b0;
        end
      end
      if (o_Ack != '0) begin
        checks++;
        if (!$onehot(o_Ack)) begin
          errors++;
          $display("FAIL ack_onehot: got o_Ack=%b, required exactly one bit", o_Ack);
        end
        for (int k = 0; k < N; k++) begin
          if (o_Ack[k]) begin
            if (hd[k] == tl[k]) begin
              errors++;
              $display("FAIL ack_unrequested: got ack for requester %0d, required none", k);
            end
            pend[k] = 1;
            ack_cnt[k]++;
          end
        end
        last_ack_cyc = cyc;
      end
      if (o_Start) begin
        n_starts++;
        start_cyc_q.push_back(cyc);
        lock_obs_q.push_back(o_Locked);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL start_unexpected: got data=%h grant=%b, required no start", o_Data, o_Grant);
        end else begin
          e_cur = exp_q.pop_front();
          if (o_Data !== e_cur.data || o_Grant !== (N'(1) << e_cur.own)) begin
            errors++;
            $display("FAIL start_byte: got data=%h grant=%b, required data=%h grant=%b",
                     o_Data, o_Grant, e_cur.data, N'(1) << e_cur.own);
          end
        end
        checks++;
        if (cyc != last_ack_cyc + 1 || i_Busy !== 1'b0) begin
          errors++;
          $display("FAIL ack_to_start: got %0d cycles busy=%b, required 1 cycle busy=0",
                   cyc - last_ack_cyc, i_Busy);
        end
      end
    end
  end

  // UART model: busy rises busy_delay cycles after start and stays high busy_len cycles.
  initial begin
    i_Busy = 1'b0;
    forever begin
      @(posedge Clock);
      #1;
      if (o_Start && !busy_never) begin
        repeat (busy_delay) @(posedge Clock);
        #1;
        i_Busy = 1'b1;
        repeat (busy_len) @(posedge Clock);
        #1;
        i_Busy = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic last);
    mem[k][tl[k] % 16] = {last, d};
    tl[k] = tl[k] + 1;
  endtask

  task automatic expect_byte(input int k, input logic [7:0] d);
    exp_t e;
    e.own  = 2'(k);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic clear_counts();
    for (int k = 0; k < N; k++) ack_cnt[k] = 0;
    start_cyc_q.delete();
    lock_obs_q.delete();
  endtask

  function automatic bit all_idle();
    bit q_empty;
    q_empty = 1'b1;
    for (int k = 0; k < N; k++) if (hd[k] != tl[k]) q_empty = 1'b0;
    return q_empty && exp_q.size() == 0 && o_Grant == '0 && !i_Busy && !o_Locked;
  endfunction

  task automatic wait_drain(input int budget, input string name);
    int i;
    i = 0;
    while (!all_idle() && i < budget) begin
      tick();
      i++;
    end
    checks++;
    if (!all_idle()) begin
      errors++;
      $display("FAIL %s_drain: got pending=%0d grant=%b after %0d cycles, required idle",
               name, exp_q.size(), o_Grant, budget);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #3;  // before the first clock edge: reset must act asynchronously
    checks += 5;
    if (o_Ack !== '0)     begin errors++; $display("FAIL reset_ack: got %b, required 0", o_Ack); end
    if (o_Grant !== '0)   begin errors++; $display("FAIL reset_grant: got %b, required 0", o_Grant); end
    if (o_Locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b, required 0", o_Locked); end
    if (o_Start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b, required 0", o_Start); end
    if (o_Data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h, required 00", o_Data); end
    repeat (2) tick();
    Reset = 1'b0;
    repeat (2) tick();
  endtask

  // Fresh pointer: order 0,1,2,3 then requester 0's second byte.
  task automatic test_round_robin();
    clear_counts();
    push(0, 8'h10, 1'b1); push(0, 8'h14, 1'b1);
    push(1, 8'h11, 1'b1); push(2, 8'h12, 1'b1); push(3, 8'h13, 1'b1);
    expect_byte(0, 8'h10); expect_byte(1, 8'h11); expect_byte(2, 8'h12);
    expect_byte(3, 8'h13); expect_byte(0, 8'h14);
    wait_drain(400, "rr");
    checks++;
    if (ack_cnt[0] != 2 || ack_cnt[1] != 1 || ack_cnt[2] != 1 || ack_cnt[3] != 1) begin
      errors++;
      $display("FAIL rr_acks: got %0d %0d %0d %0d, required 2 1 1 1",
               ack_cnt[0], ack_cnt[1], ack_cnt[2], ack_cnt[3]);
    end
  endtask

  task automatic test_single_byte();
    bit lock_seen;
    bit busy_grant_bad;
    int i;
    clear_counts();
    busy_len = 100;
    lock_seen = 0;
    busy_grant_bad = 0;
    push(2, 8'h61, 1'b1);
    expect_byte(2, 8'h61);
    i = 0;
    tick();
    while (!all_idle() && i < 300) begin
      if (o_Locked) lock_seen = 1;
      if (i_Busy && o_Grant !== 4'b0100) busy_grant_bad = 1;
      tick();
      i++;
    end
    checks += 5;
    if (!all_idle()) begin errors++; $display("FAIL single_drain: got pending, required idle"); end
    if (lock_seen) begin errors++; $display("FAIL single_locked: got 1, required 0"); end
    if (busy_grant_bad) begin errors++; $display("FAIL single_grant: got not 0100 while busy, required 0100"); end
    if (ack_cnt[2] != 1) begin errors++; $display("FAIL single_ack: got %0d, required 1", ack_cnt[2]); end
    if (start_cyc_q.size() != 1 || start_cyc_q[0] - rise_cyc[2] != 2) begin
      errors++;
      $display("FAIL single_latency: got %0d starts, req-to-start %0d, required 1 start, 2 cycles",
               start_cyc_q.size(), (start_cyc_q.size() > 0) ? start_cyc_q[0] - rise_cyc[2] : -1);
    end
    busy_len = 20;
  endtask

  task automatic test_packet_lock();
    int i;
    clear_counts();
    push(1, 8'h61, 1'b0); push(1, 8'h62, 1'b0); push(1, 8'h0A, 1'b1);
    expect_byte(1, 8'h61); expect_byte(1, 8'h62); expect_byte(1, 8'h0A); expect_byte(0, 8'h30);
    i = 0;
    while (ack_cnt[1] == 0 && i < 20) begin tick(); i++; end
    push(0, 8'h30, 1'b1);
    wait_drain(400, "lock");
    checks++;
    if (lock_obs_q.size() != 4 || lock_obs_q[0] !== 1'b1 || lock_obs_q[1] !== 1'b1 ||
        lock_obs_q[2] !== 1'b0 || lock_obs_q[3] !== 1'b0) begin
      errors++;
      $display("FAIL lock_flag: got %0d starts with locked %p, required 4 starts with 1 1 0 0",
               lock_obs_q.size(), lock_obs_q);
    end
  endtask

  task automatic test_lock_gap();
    int i;
    int s0;
    bit gap_bad;
    clear_counts();
    gap_bad = 0;
    s0 = n_starts;
    push(3, 8'hA0, 1'b0);
    push(0, 8'h31, 1'b1);
    expect_byte(3, 8'hA0); expect_byte(3, 8'hA1); expect_byte(0, 8'h31);
    i = 0;
    while (n_starts == s0 && i < 20) begin tick(); i++; end
    repeat (30) tick();
    for (int j = 0; j < 50; j++) begin
      if (o_Grant !== 4'b1000 || o_Locked !== 1'b1 || ack_cnt[0] != 0) gap_bad = 1;
      tick();
    end
    checks++;
    if (gap_bad) begin
      errors++;
      $display("FAIL gap_hold: got grant=%b locked=%b ack0=%0d, required 1000 1 0",
               o_Grant, o_Locked, ack_cnt[0]);
    end
    push(3, 8'hA1, 1'b1);
    wait_drain(300, "gap");
    checks++;
    if (ack_cnt[3] != 2 || ack_cnt[0] != 1) begin
      errors++;
      $display("FAIL gap_acks: got ack3=%0d ack0=%0d, required 2 1", ack_cnt[3], ack_cnt[0]);
    end
  endtask

  // Done 16 cycles after start, then IDLE, LOAD, START: next start 19 cycles later.
  task automatic test_busy_timeout();
    clear_counts();
    busy_never = 1'b1;
    push(1, 8'h41, 1'b1);
    push(2, 8'h42, 1'b1);
    expect_byte(1, 8'h41); expect_byte(2, 8'h42);
    wait_drain(200, "timeout");
    checks++;
    if (start_cyc_q.size() != 2 || start_cyc_q[1] - start_cyc_q[0] != 19) begin
      errors++;
      $display("FAIL timeout_gap: got %0d starts gap %0d, required 2 starts gap 19",
               start_cyc_q.size(), (start_cyc_q.size() == 2) ? start_cyc_q[1] - start_cyc_q[0] : -1);
    end
    busy_never = 1'b0;
  endtask

  task automatic test_reset_mid();
    int i;
    clear_counts();
    busy_len = 40;
    push(1, 8'h55, 1'b1);
    expect_byte(1, 8'h55);
    i = 0;
    while (!i_Busy && i < 30) begin tick(); i++; end
    checks++;
    if (!i_Busy) begin errors++; $display("FAIL mid_busy: got busy=0, required 1"); end
    repeat (3) tick();
    Reset = 1'b1;
    #1;
    checks++;
    if (o_Ack !== '0 || o_Grant !== '0 || o_Locked !== 1'b0 || o_Start !== 1'b0 ||
        o_Data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: got ack=%b grant=%b lock=%b start=%b data=%h, required all 0",
               o_Ack, o_Grant, o_Locked, o_Start, o_Data);
    end
    for (int k = 0; k < N; k++) begin hd[k] = tl[k]; pend[k] = 0; end
    exp_q.delete();
    repeat (2) tick();
    Reset = 1'b0;
    i = 0;
    while (i_Busy && i < 60) begin tick(); i++; end
    push(0, 8'h70, 1'b1);
    push(2, 8'h72, 1'b1);
    expect_byte(0, 8'h70); expect_byte(2, 8'h72);
    wait_drain(300, "mid");
    checks++;
    if (ack_cnt[0] != 1 || ack_cnt[1] != 1 || ack_cnt[2] != 1) begin
      errors++;
      $display("FAIL mid_acks: got %0d %0d %0d, required 1 1 1", ack_cnt[0], ack_cnt[1], ack_cnt[2]);
    end
    busy_len = 20;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_byte();
    test_packet_lock();
    test_lock_gap();
    test_busy_timeout();
    test_reset_mid();
    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
